// File: rtl/alu_issue_stage.sv
// Two-stage elastic issue/writeback stage for the RV32I integer ALU.
// S1 holds the decoded ALU operands. S2 holds the captured result for register writeback.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_AND  = 4'b0010;
    localparam logic [3:0] CTRL_OR   = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLT  = 4'b0101;
    localparam logic [3:0] CTRL_SLTU = 4'b0110;
    localparam logic [3:0] CTRL_ILL  = 4'b1111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        rs1_idx_unused;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm    = {{20{in_instr[31]}}, in_instr[31:20]};
    // The rs1 index is not needed because the operand value arrives already fetched.
    assign rs1_idx_unused = ^in_instr[19:15];

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic        dec_illegal;

    always_comb begin
        dec_illegal = 1'b0;
        dec_ctrl    = CTRL_ADD;
        dec_b       = in_rs2_val;
        case (opcode)
            OPC_R: begin
                dec_b = in_rs2_val;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_ctrl = CTRL_ADD;
                    {7'b0100000, 3'b000}: dec_ctrl = CTRL_SUB;
                    {7'b0000000, 3'b111}: dec_ctrl = CTRL_AND;
                    {7'b0000000, 3'b110}: dec_ctrl = CTRL_OR;
                    {7'b0000000, 3'b100}: dec_ctrl = CTRL_XOR;
                    {7'b0000000, 3'b010}: dec_ctrl = CTRL_SLT;
                    {7'b0000000, 3'b011}: dec_ctrl = CTRL_SLTU;
                    default:              dec_illegal = 1'b1;
                endcase
            end
            OPC_I: begin
                dec_b = imm;
                case (funct3)
                    3'b000:  dec_ctrl = CTRL_ADD;
                    3'b111:  dec_ctrl = CTRL_AND;
                    3'b110:  dec_ctrl = CTRL_OR;
                    3'b100:  dec_ctrl = CTRL_XOR;
                    3'b010:  dec_ctrl = CTRL_SLT;
                    3'b011:  dec_ctrl = CTRL_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_a = in_rs1_val;
        // Illegal entries present a fixed, recognisable pattern to the ALU.
        if (dec_illegal) begin
            dec_a    = 32'd0;
            dec_b    = 32'd0;
            dec_ctrl = CTRL_ILL;
        end
    end

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic        s1_illegal_q, s1_illegal_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_illegal_q, out_illegal_d;

    logic s2_free;
    logic s1_adv;
    logic accept;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d    = s1_valid_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        s1_rd_d       = s1_rd_q;
        s1_illegal_d  = s1_illegal_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;

        if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d   = 1'b1;
            alu_a_d      = dec_a;
            alu_b_d      = dec_b;
            alu_ctrl_d   = dec_ctrl;
            s1_rd_d      = in_instr[11:7];
            s1_illegal_d = dec_illegal;
        end

        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (s1_adv) begin
            out_valid_d   = 1'b1;
            out_result_d  = s1_illegal_q ? 32'd0 : alu_result;
            out_rd_d      = s1_rd_q;
            out_illegal_d = s1_illegal_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_ctrl_q    <= 4'b0000;
            s1_rd_q       <= 5'd0;
            s1_illegal_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'd0;
            out_rd_q      <= 5'd0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            s1_rd_q       <= s1_rd_d;
            s1_illegal_q  <= s1_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;
    assign out_we      = out_valid_q && !out_illegal_q && (out_rd_q != 5'd0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected results are queued at acceptance and popped when
// the writeback stage hands an entry over. The ALU itself is modelled here.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_we;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_we(out_we), .out_illegal(out_illegal)
    );

    // Single-cycle ALU attached to the stage.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_control)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Result an RV32I machine would write back, or an illegal marker.
    function automatic exp_t ref_model(input logic [31:0] instr, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] op2;
        logic        is_r;
        logic        is_i;
        opc  = instr[6:0];
        f3   = instr[14:12];
        f7   = instr[31:25];
        imm  = {{20{instr[31]}}, instr[31:20]};
        is_r = (opc == 7'b0110011);
        is_i = (opc == 7'b0010011);
        op2  = is_r ? y : imm;
        e.rd  = instr[11:7];
        e.ill = 1'b0;
        e.res = 32'd0;
        if (!is_r && !is_i) e.ill = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) e.ill = 1'b1;
        if (is_r && !(f7 == 7'd0 || (f7 == 7'b0100000 && f3 == 3'b000))) e.ill = 1'b1;
        if (!e.ill) begin
            case (f3)
                3'b000:  e.res = (is_r && f7 == 7'b0100000) ? x - op2 : x + op2;
                3'b111:  e.res = x & op2;
                3'b110:  e.res = x | op2;
                3'b100:  e.res = x ^ op2;
                3'b010:  e.res = ($signed(x) < $signed(op2)) ? 32'd1 : 32'd0;
                3'b011:  e.res = (x < op2) ? 32'd1 : 32'd0;
                default: e.res = 32'd0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] im, input logic [2:0] f3, input logic [4:0] rd);
        return {im, 5'd1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        logic [2:0]  f3;
        logic [6:0]  f7;
        sel = int'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        w   = $urandom;
        if (sel < 4) begin
            if ($urandom_range(0, 3) == 0) f7 = 7'($urandom);
            else if (f3 == 3'b000 && $urandom_range(0, 1) == 1) f7 = 7'b0100000;
            else f7 = 7'd0;
            w = {f7, w[24:15], f3, w[11:7], 7'b0110011};
        end else if (sel < 7) begin
            w = {w[31:15], f3, w[11:7], 7'b0010011};
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v = 32'($urandom_range(0, 15)) - 32'd8;
        return v;
    endfunction

    // Scoreboard monitor: samples on the falling edge, the handshakes seen here complete at the next rising edge.
    logic        prev_ok = 1'b0;
    logic        prev_out_stall, prev_in_block;
    logic [31:0] prev_res, prev_a, prev_b;
    logic [4:0]  prev_rd;
    logic [3:0]  prev_ctrl;
    logic        prev_ill, prev_valid;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_out_stall) begin
                check("hold_out_valid", {31'd0, out_valid}, {31'd0, prev_valid});
                check("hold_out_result", out_result, prev_res);
                check("hold_out_rd", {27'd0, out_rd}, {27'd0, prev_rd});
                check("hold_out_illegal", {31'd0, out_illegal}, {31'd0, prev_ill});
            end
            if (prev_ok && prev_in_block) begin
                check("hold_alu_a", alu_a, prev_a);
                check("hold_alu_b", alu_b, prev_b);
                check("hold_alu_control", {28'd0, alu_control}, {28'd0, prev_ctrl});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    check("sb_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    check("sb_we", {31'd0, out_we}, {31'd0, !e.ill && e.rd != 5'd0});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(in_instr, in_rs1_val, in_rs2_val));
            prev_ok        = 1'b1;
            prev_out_stall = out_valid && !out_ready;
            prev_in_block  = !in_ready;
            prev_valid     = out_valid;
            prev_res       = out_result;
            prev_rd        = out_rd;
            prev_ill       = out_illegal;
            prev_a         = alu_a;
            prev_b         = alu_b;
            prev_ctrl      = alu_control;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the instruction.
    task automatic send(input logic [31:0] instr, input logic [31:0] x, input logic [31:0] y);
        bit taken;
        taken      = 1'b0;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = x;
        in_rs2_val = y;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!taken) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_instr [3];
        logic [31:0] bp_a [3];
        logic [31:0] bp_b [3];
        int          idx;
        int          acc;
        bit          took;

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_instr   = r_type(7'd0, 3'b000, 5'd3);
        in_rs1_val = 32'd1;
        in_rs2_val = 32'd2;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_alu_control", {28'd0, alu_control}, 32'd0);
        check("rst_out_we", {31'd0, out_we}, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Latency: empty S2 one edge after acceptance, result one edge later.
        send(r_type(7'd0, 3'b000, 5'd3), 32'd5, 32'd7);
        @(negedge clk);
        check("lat_s2_empty", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_s2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_add_result", out_result, 32'd12);
        check("lat_add_rd", {27'd0, out_rd}, 32'd3);
        check("lat_add_we", {31'd0, out_we}, 32'd1);

        // Back-to-back ADD then SUB without a bubble.
        @(posedge clk);
        #1;
        send(r_type(7'd0, 3'b000, 5'd3), 32'd5, 32'd7);
        send(r_type(7'b0100000, 3'b000, 5'd3), 32'd5, 32'd7);
        @(negedge clk);
        check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_add_result", out_result, 32'd12);
        @(negedge clk);
        check("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_sub_result", out_result, 32'hFFFFFFFE);

        @(posedge clk);
        #1;
        send(i_type(12'hFFF, 3'b000, 5'd4), 32'd10, 32'd0);
        @(negedge clk);
        check("addi_alu_b", alu_b, 32'hFFFFFFFF);
        @(negedge clk);
        check("addi_result", out_result, 32'd9);
        @(posedge clk);
        #1;
        send(i_type(12'h0F0, 3'b111, 5'd5), 32'h0000FFFF, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("andi_result", out_result, 32'h000000F0);
        @(posedge clk);
        #1;
        send(i_type(12'd5, 3'b011, 5'd6), 32'd3, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("sltiu_result", out_result, 32'd1);

        // Backpressure: three offered while the consumer stalls.
        bp_instr[0] = r_type(7'd0, 3'b000, 5'd5);
        bp_instr[1] = r_type(7'b0100000, 3'b000, 5'd6);
        bp_instr[2] = r_type(7'd0, 3'b100, 5'd7);
        for (int i = 0; i < 3; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        idx        = 0;
        acc        = 0;
        in_valid   = 1'b1;
        in_instr   = bp_instr[0];
        in_rs1_val = bp_a[0];
        in_rs2_val = bp_b[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            took = in_ready && in_valid;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                in_instr   = bp_instr[idx];
                in_rs1_val = bp_a[idx];
                in_rs2_val = bp_b[idx];
            end
        end
        @(negedge clk);
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(bp_instr[2], bp_a[2], bp_b[2]);
        repeat (4) @(negedge clk);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Illegal shift and writes to x0.
        @(posedge clk);
        #1;
        send(r_type(7'd0, 3'b001, 5'd8), 32'd3, 32'd4);
        @(negedge clk);
        check("ill_alu_control", {28'd0, alu_control}, 32'hF);
        check("ill_alu_a", alu_a, 32'd0);
        @(negedge clk);
        check("ill_out_illegal", {31'd0, out_illegal}, 32'd1);
        check("ill_out_result", out_result, 32'd0);
        check("ill_out_we", {31'd0, out_we}, 32'd0);
        @(posedge clk);
        #1;
        send(r_type(7'd0, 3'b000, 5'd0), 32'd100, 32'd23);
        @(negedge clk);
        @(negedge clk);
        check("x0_we", {31'd0, out_we}, 32'd0);
        check("x0_result", out_result, 32'd123);

        // Reset with both stages full.
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = r_type(7'd0, 3'b110, 5'd9);
        in_rs1_val = 32'h0F0F0000;
        in_rs2_val = 32'h000000F0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_no_output", {31'd0, out_valid}, 32'd0);

        // Randomized traffic with random backpressure.
        @(posedge clk);
        #1;
        for (int c = 0; c < 800; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_instr   = rand_instr();
            in_rs1_val = rand_val();
            in_rs2_val = rand_val();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Two-stage elastic issue/writeback stage that feeds the single-cycle ALU and collects its result. Accepts one RV32I integer instruction per cycle with its register operands over a valid/ready handshake. Decodes it into ALU operands and the 4-bit ALU control code, drives the ALU combinationally from a registered issue stage, and registers the result with destination-register information for the register-file writer. Sits between operand fetch and register writeback in the microcontroller datapath.

## Interface
- No parameters; data width fixed at 32, ALU control width fixed at 4.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  instruction + operands valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_rs1_val  in  32  value of rs1
- in_rs2_val  in  32  value of rs2
- alu_a  out  32  ALU operand a (issue-stage register)
- alu_b  out  32  ALU operand b (issue-stage register)
- alu_control  out  4  ALU op code (issue-stage register)
- alu_result  in  32  combinational ALU result for alu_a/alu_b/alu_control
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback consumer accepts
- out_rd  out  5  destination register index
- out_result  out  32  registered ALU result
- out_we  out  1  register-file write enable (out_valid & !out_illegal & out_rd != 0)
- out_illegal  out  1  instruction not supported by this stage

## Operation
- Decode fields: opcode = instr[6:0], rd = instr[11:7], funct3 = instr[14:12], funct7 = instr[31:25], imm = sign-extended instr[31:20].
- Opcode 0110011 (R-type): alu_b = rs2_val. funct3/funct7: 000/0000000 ADD 0000; 000/0100000 SUB 0001; 111/0000000 AND 0010; 110/0000000 OR 0011; 100/0000000 XOR 0100; 010/0000000 SLT 0101; 011/0000000 SLTU 0110.
- Opcode 0010011 (I-type): alu_b = imm. funct3 000 ADDI 0000; 111 ANDI 0010; 110 ORI 0011; 100 XORI 0100; 010 SLTI 0101; 011 SLTIU 0110.
- alu_a = rs1_val for every legal op.
- Everything else is illegal: other opcodes, funct3 001/101 (shifts), and R-type with an unlisted funct7. Illegal entries still flow through the pipe. Issue stage loads alu_a = 0, alu_b = 0, alu_control = 4'b1111; the writeback result is forced to 0 and out_illegal = 1.
- Issue stage (S1) registers: s1_valid, alu_a, alu_b, alu_control, s1_rd, s1_illegal.
- Writeback stage (S2) registers: out_valid, out_result, out_rd, out_illegal.
- Advance rules:
  - s2_free = !out_valid | out_ready.
  - S1 moves to S2 when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free.
  - Input is accepted on in_valid & in_ready.
- S2 holds all outputs stable while out_valid & !out_ready.
- S1 holds while S2 is stalled, so alu_a/alu_b/alu_control stay stable.
- Data registers load only on transfer. Valid flags clear when their entry is consumed and no new entry replaces it.

## Timing
- Reset (rst_n low at a clk edge): s1_valid, out_valid = 0; alu_a, alu_b, out_result = 0; alu_control = 4'b0000; out_rd = 0; out_illegal = 0. Hence in_ready = 1 and out_we = 0.
- Reset asserted mid-operation discards all in-flight entries in that cycle, regardless of handshakes.
- Latency: an instruction accepted at edge N appears in S1 after N and in S2 after N+1. out_valid is therefore visible in the cycle after edge N+1.
- Throughput: one instruction per cycle with out_ready held high. No bubbles at any fill level.
- Full: both stages valid and out_ready = 0 gives in_ready = 0. No entry is lost or duplicated.
- Simultaneous events: accept into S1, move S1→S2, and consume S2 can all occur in the same cycle.
- in_ready depends combinationally on out_ready; no other comb paths from inputs to outputs.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, alu_control = 0000. After release, the first accepted instruction appears in S2 exactly 2 edges later.
- Back-to-back R-type, out_ready = 1:
  - ADD x3,x1,x2 (rs1 = 5, rs2 = 7) → out_result = 12, out_rd = 3, out_we = 1.
  - Next cycle SUB (rs1 = 5, rs2 = 7) → out_result = 0xFFFFFFFE.
  - No bubbles between the two results.
- I-type: ADDI x4,x1,-1 (rs1 = 10) → alu_b = 0xFFFFFFFF, out_result = 9. ANDI imm 0x0F0 with rs1 = 0xFFFF → 0x00F0. SLTIU imm 5 with rs1 = 3 → 1.
- Backpressure: out_ready = 0 for 3 cycles while 3 instructions are offered → exactly 2 accepted, in_ready = 0. alu_*, out_* stay stable throughout. On release, the 3 results emerge in order and none are dropped.
- Illegal and x0:
  - SLL (funct3 001) → out_illegal = 1, out_result = 0, out_we = 0, alu_control = 1111.
  - ADD with rd = 0 → out_we = 0, out_result still the correct sum.
- Reset mid-stream: assert rst_n = 0 with both stages full → next cycle out_valid = 0, s1 empty, in_ready = 1.
